// File: rtl/cordic_pkg.sv
// Shared angle constants, fold/mode encodings and angle scaling helper for the CORDIC pre-processor.
// Angles are signed Q3.29 at the 32-bit reference width.
package cordic_pkg;

  // pi is defined as exactly 2*(pi/2) so the +/-pi and +/-pi/2 folds undo each other without residue
  localparam logic signed [31:0] ANG_PI_2 = 32'sd843314856;
  localparam logic signed [31:0] ANG_PI   = 32'sd1686629712;

  typedef enum logic [1:0] {
    FOLD_NONE = 2'b00,
    FOLD_PPI  = 2'b01,
    FOLD_MPI  = 2'b10,
    FOLD_HPI  = 2'b11
  } fold_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // Rescale a Q3.29 reference constant to a Q3.(w-3) angle of width w
  function automatic logic signed [63:0] ang_scale(input logic signed [31:0] a, input int w);
    logic signed [63:0] v;
    v = 64'(a);
    if (w >= 32) ang_scale = v <<< (w - 32);
    else         ang_scale = v >>> (32 - w);
  endfunction

endpackage

// File: rtl/cordic_preproc_hs_if.sv
// Input/output beat bundle for the CORDIC pre-processor; slave = the block, master = its environment.
// Both handshakes use valid/ready; output fields are meaningful while m_valid is high.
interface cordic_preproc_hs_if #(
  parameter int XY_W    = 16,
  parameter int XYI     = 19,
  parameter int ANGLE_W = 32,
  parameter int TAG_W   = 4
);
  logic                      s_valid;
  logic                      s_ready;
  logic                      mode;
  logic signed [XY_W-1:0]    x_in;
  logic signed [XY_W-1:0]    y_in;
  logic signed [ANGLE_W-1:0] z_in;
  logic [TAG_W-1:0]          tag_in;
  logic                      m_valid;
  logic                      m_ready;
  logic signed [XYI:0]       x0;
  logic signed [XYI:0]       y0;
  logic signed [ANGLE_W-1:0] z0;
  logic [1:0]                fold;
  logic                      mode_out;
  logic [TAG_W-1:0]          tag_out;
  logic                      range_err;

  modport master (
    output s_valid, mode, x_in, y_in, z_in, tag_in, m_ready,
    input  s_ready, m_valid, x0, y0, z0, fold, mode_out, tag_out, range_err
  );

  modport slave (
    input  s_valid, mode, x_in, y_in, z_in, tag_in, m_ready,
    output s_ready, m_valid, x0, y0, z0, fold, mode_out, tag_out, range_err
  );
endinterface

// File: rtl/cordic_hs_stage.sv
// One valid/ready register slice; latency 1, full throughput, data held stable while stalled.
// in_ready = rst_n & ce & (!out_valid | out_ready), so ready depends combinationally on out_ready.
module cordic_hs_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = rst_n & ce & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/cordic_preproc_hs.sv
// Folds rotation angles / vectoring vectors into [-pi/2, pi/2] ahead of the CORDIC iterations.
// Latency 1 (IN_REG=0) or 2 (IN_REG=1), 1 beat/cycle; s_ready follows m_ready combinationally, ce=0 freezes.
module cordic_preproc_hs
  import cordic_pkg::*;
#(
  parameter int XY_W    = 16,
  parameter int XYI     = 19,
  parameter int ANGLE_W = 32,
  parameter int TAG_W   = 4,
  parameter bit IN_REG  = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              ce,
  cordic_preproc_hs_if.slave bus
);

  localparam logic signed [ANGLE_W-1:0] PI_W  = ANGLE_W'(ang_scale(ANG_PI, ANGLE_W));
  localparam logic signed [ANGLE_W-1:0] PI2_W = ANGLE_W'(ang_scale(ANG_PI_2, ANGLE_W));

  typedef struct packed {
    mode_e                     mode;
    logic signed [XY_W-1:0]    x;
    logic signed [XY_W-1:0]    y;
    logic signed [ANGLE_W-1:0] z;
    logic [TAG_W-1:0]          tag;
  } in_beat_t;

  typedef struct packed {
    logic signed [XYI:0]       x0;
    logic signed [XYI:0]       y0;
    logic signed [ANGLE_W-1:0] z0;
    fold_e                     fold;
    mode_e                     mode;
    logic [TAG_W-1:0]          tag;
    logic                      range_err;
  } out_beat_t;

  in_beat_t            s_beat;
  in_beat_t            f_beat;
  out_beat_t           f_out;
  out_beat_t           o_beat;
  logic                f_valid;
  logic                f_ready;
  logic signed [XYI:0] xe;
  logic signed [XYI:0] ye;

  assign s_beat = '{mode: mode_e'(bus.mode), x: bus.x_in, y: bus.y_in, z: bus.z_in, tag: bus.tag_in};

  generate
    if (IN_REG) begin : g_in_reg
      cordic_hs_stage #(.W($bits(in_beat_t))) u_in_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .in_valid  (bus.s_valid),
        .in_ready  (bus.s_ready),
        .in_data   (s_beat),
        .out_valid (f_valid),
        .out_ready (f_ready),
        .out_data  (f_beat)
      );
    end else begin : g_no_in_reg
      assign f_valid     = bus.s_valid;
      assign bus.s_ready = f_ready;
      assign f_beat      = s_beat;
    end
  endgenerate

  // One guard bit above XY_W makes negating the most negative input exact
  assign xe = {{(XYI + 1 - XY_W){f_beat.x[XY_W-1]}}, f_beat.x};
  assign ye = {{(XYI + 1 - XY_W){f_beat.y[XY_W-1]}}, f_beat.y};

  always_comb begin
    f_out.x0        = xe;
    f_out.y0        = ye;
    f_out.z0        = f_beat.z;
    f_out.fold      = FOLD_NONE;
    f_out.mode      = f_beat.mode;
    f_out.tag       = f_beat.tag;
    f_out.range_err = 1'b0;
    if (f_beat.mode == MODE_ROT) begin
      if (f_beat.z > PI_W || f_beat.z < -PI_W) begin
        f_out.range_err = 1'b1;
      end else if (f_beat.z > PI2_W) begin
        f_out.z0   = f_beat.z - PI_W;
        f_out.x0   = -xe;
        f_out.y0   = -ye;
        f_out.fold = FOLD_MPI;
      end else if (f_beat.z < -PI2_W) begin
        f_out.z0   = f_beat.z + PI_W;
        f_out.x0   = -xe;
        f_out.y0   = -ye;
        f_out.fold = FOLD_PPI;
      end
    end else begin
      f_out.z0 = '0;
      if (xe == '0) begin
        // Vector on the y axis: rotate by -/+pi/2 onto +x
        f_out.x0   = ye[XYI] ? -ye : ye;
        f_out.y0   = '0;
        f_out.z0   = ye[XYI] ? -PI2_W : PI2_W;
        f_out.fold = FOLD_HPI;
      end else if (xe[XYI]) begin
        f_out.x0   = -xe;
        f_out.y0   = -ye;
        f_out.z0   = ye[XYI] ? -PI_W : PI_W;
        f_out.fold = ye[XYI] ? FOLD_MPI : FOLD_PPI;
      end
    end
  end

  cordic_hs_stage #(.W($bits(out_beat_t))) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (f_valid),
    .in_ready  (f_ready),
    .in_data   (f_out),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_data  (o_beat)
  );

  assign bus.x0        = o_beat.x0;
  assign bus.y0        = o_beat.y0;
  assign bus.z0        = o_beat.z0;
  assign bus.fold      = o_beat.fold;
  assign bus.mode_out  = o_beat.mode;
  assign bus.tag_out   = o_beat.tag;
  assign bus.range_err = o_beat.range_err;

endmodule

// File: tb/tb_cordic_preproc_hs.sv
// Bench for cordic_preproc_hs: both IN_REG variants, directed fold cases, randomized backpressured stream,
// ce freeze and reset with beats in flight, scored against a spec-level fold model.
module tb_cordic_preproc_hs;

  localparam longint PI  = 64'sd1686629712;
  localparam longint PI2 = 64'sd843314856;

  typedef struct {
    longint x0, y0, z0;
    int     fold, mode, tag, rerr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, ce, s_valid, m_ready, mode;
  logic signed [15:0] x_in, y_in;
  logic signed [31:0] z_in;
  logic [3:0]         tag_in;
  int                 sel;
  int                 checks = 0;
  int                 errors = 0;
  exp_t               exp_q[$];

  cordic_preproc_hs_if bus0 ();
  cordic_preproc_hs_if bus1 ();

  assign bus0.s_valid = s_valid && (sel == 0);
  assign bus0.m_ready = m_ready && (sel == 0);
  assign bus1.s_valid = s_valid && (sel == 1);
  assign bus1.m_ready = m_ready && (sel == 1);
  assign bus0.mode = mode;   assign bus1.mode = mode;
  assign bus0.x_in = x_in;   assign bus1.x_in = x_in;
  assign bus0.y_in = y_in;   assign bus1.y_in = y_in;
  assign bus0.z_in = z_in;   assign bus1.z_in = z_in;
  assign bus0.tag_in = tag_in; assign bus1.tag_in = tag_in;

  cordic_preproc_hs #(.IN_REG(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus0));
  cordic_preproc_hs #(.IN_REG(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(bus1));

  logic               o_srdy, o_mvld, o_mode, o_rerr;
  logic signed [19:0] o_x0, o_y0;
  logic signed [31:0] o_z0;
  logic [1:0]         o_fold;
  logic [3:0]         o_tag;

  always_comb begin
    if (sel == 0) begin
      o_srdy = bus0.s_ready; o_mvld = bus0.m_valid; o_x0 = bus0.x0; o_y0 = bus0.y0;
      o_z0 = bus0.z0; o_fold = bus0.fold; o_mode = bus0.mode_out; o_tag = bus0.tag_out;
      o_rerr = bus0.range_err;
    end else begin
      o_srdy = bus1.s_ready; o_mvld = bus1.m_valid; o_x0 = bus1.x0; o_y0 = bus1.y0;
      o_z0 = bus1.z0; o_fold = bus1.fold; o_mode = bus1.mode_out; o_tag = bus1.tag_out;
      o_rerr = bus1.range_err;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (IN_REG=%0d): got %0d expected %0d", tag, sel, got, exp);
    end
  endtask

  // What the folded beat must be, straight from the fold rules
  function automatic exp_t model(input int md, input longint x, input longint y, input longint z, input int tag);
    exp_t e;
    e.x0 = x; e.y0 = y; e.z0 = z; e.fold = 0; e.mode = md; e.tag = tag; e.rerr = 0;
    if (md == 0) begin
      if (z > PI || z < -PI) e.rerr = 1;
      else if (z > PI2)  begin e.z0 = z - PI; e.x0 = -x; e.y0 = -y; e.fold = 2; end
      else if (z < -PI2) begin e.z0 = z + PI; e.x0 = -x; e.y0 = -y; e.fold = 1; end
    end else begin
      e.z0 = 0;
      if (x == 0) begin
        e.x0 = (y < 0) ? -y : y; e.y0 = 0; e.z0 = (y < 0) ? -PI2 : PI2; e.fold = 3;
      end else if (x < 0) begin
        e.x0 = -x; e.y0 = -y; e.z0 = (y < 0) ? -PI : PI; e.fold = (y < 0) ? 2 : 1;
      end
    end
    return e;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  logic   p_vld, p_take;
  longint px0, pz0;
  int     ptag;
  exp_t   e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      p_vld = 1'b0; p_take = 1'b0;
    end else begin
      if (p_vld && !p_take) begin
        chk("hold_vld", o_mvld, 1);
        chk("hold_x0", o_x0, px0);
        chk("hold_z0", o_z0, pz0);
        chk("hold_tag", o_tag, ptag);
      end
      p_vld = o_mvld; p_take = o_mvld && m_ready && ce;
      px0 = o_x0; pz0 = o_z0; ptag = o_tag;
      if (o_mvld && m_ready && ce) begin
        if (exp_q.size() == 0) chk("spurious_vld", o_mvld, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_x0", o_x0, e.x0);     chk("sb_y0", o_y0, e.y0);
          chk("sb_z0", o_z0, e.z0);     chk("sb_fold", o_fold, e.fold);
          chk("sb_mode", o_mode, e.mode); chk("sb_tag", o_tag, e.tag);
          chk("sb_rerr", o_rerr, e.rerr);
        end
      end
      if (s_valid && o_srdy) exp_q.push_back(model(mode, x_in, y_in, z_in, tag_in));
    end
  end

  task automatic send_chk(input string nm, input logic md, input longint x, input longint y, input longint z,
                          input longint ex0, input longint ey0, input longint ez0, input int efold, input int erng);
    int n;
    mode = md; x_in = 16'(x); y_in = 16'(y); z_in = 32'(z); tag_in = 4'($urandom);
    s_valid = 1'b1; m_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_srdy || n > 20) break;
      n++;
    end
    chk({nm, "_srdy"}, o_srdy, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    n = 1;
    while (!o_mvld && n < 10) begin @(posedge clk); #1; n++; end
    chk({nm, "_lat"}, n, sel + 1);
    chk({nm, "_x0"}, o_x0, ex0);   chk({nm, "_y0"}, o_y0, ey0);
    chk({nm, "_z0"}, o_z0, ez0);   chk({nm, "_fold"}, o_fold, efold);
    chk({nm, "_rerr"}, o_rerr, erng);
    @(posedge clk); #1;
  endtask

  task automatic stream();
    logic   md[8];
    longint xs[8], ys[8], zs[8];
    int     idx, cyc;
    logic   acc;
    for (int i = 0; i < 8; i++) begin
      md[i] = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       xs[i] = 0;
        1:       xs[i] = -32768;
        default: xs[i] = longint'($signed(16'($urandom)));
      endcase
      ys[i] = longint'($signed(16'($urandom)));
      zs[i] = longint'($signed(32'($urandom)));
    end
    idx = 0; cyc = 0; m_ready = 1'b1; s_valid = 1'b1;
    mode = md[0]; x_in = 16'(xs[0]); y_in = 16'(ys[0]); z_in = 32'(zs[0]); tag_in = 4'd0;
    while ((idx < 8 || exp_q.size() > 0) && cyc < 200) begin
      @(negedge clk);
      acc = s_valid && o_srdy;
      if (cyc >= 6 && cyc < 9) chk("ce_frz_srdy", o_srdy, 0);
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      ce = !(cyc >= 6 && cyc < 9);
      m_ready = (cyc % 2 == 0);
      if (idx < 8) begin
        mode = md[idx]; x_in = 16'(xs[idx]); y_in = 16'(ys[idx]); z_in = 32'(zs[idx]); tag_in = 4'(idx);
      end else s_valid = 1'b0;
    end
    ce = 1'b1;
    chk("stream_sent", idx, 8);
    chk("stream_drain", exp_q.size(), 0);
  endtask

  task automatic reset_in_flight();
    m_ready = 1'b0; ce = 1'b1; mode = 1'b1; x_in = -16'sd5; y_in = 16'sd3; tag_in = 4'd9; s_valid = 1'b1;
    @(posedge clk); #1;
    x_in = -16'sd6; tag_in = 4'd10;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("inflight_mvld", o_mvld, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_mvld", o_mvld, 0); chk("mrst_srdy", o_srdy, 0);
    chk("mrst_x0", o_x0, 0);     chk("mrst_y0", o_y0, 0);
    chk("mrst_z0", o_z0, 0);     chk("mrst_fold", o_fold, 0);
    chk("mrst_tag", o_tag, 0);   chk("mrst_mode", o_mode, 0);
    chk("mrst_rerr", o_rerr, 0);
    rst_n = 1'b1; m_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_mvld", o_mvld, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; s_valid = 1'b0; m_ready = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; tag_in = '0; sel = 0;
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0; sel = k; s_valid = 1'b0; m_ready = 1'b0; ce = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mvld", o_mvld, 0); chk("rst_srdy", o_srdy, 0);
      chk("rst_x0", o_x0, 0);     chk("rst_z0", o_z0, 0);
      chk("rst_fold", o_fold, 0); chk("rst_tag", o_tag, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_chk("vec_neg",   1'b1, -100,   50,  0, 100,   -50, PI,       1, 0);
      send_chk("vec_x0",    1'b1, 0,      -7,  0, 7,     0,   -PI2,     3, 0);
      send_chk("vec_min",   1'b1, -32768, -1,  0, 32768, 1,   -PI,      2, 0);
      send_chk("vec_pos",   1'b1, 10,     -3,  5, 10,    -3,  0,        0, 0);
      send_chk("rot_mpi",   1'b0, 1000,   0,   PI2 + 1, -1000, 0, 1 - PI2, 2, 0);
      send_chk("rot_edge",  1'b0, 123,    -45, PI2, 123, -45, PI2,      0, 0);
      send_chk("rot_ppi",   1'b0, 7,      8,   -PI2 - 1, -7, -8, PI2 - 1, 1, 0);
      send_chk("rot_range", 1'b0, 5,      6,   PI + 1, 5, 6, PI + 1,    0, 1);
      stream();
      reset_in_flight();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
